// File: rtl/prog_mem_bank_pkg.sv
// Shared types and helpers for the banked program memory (package prog_mem_pkg).
// Parity storage is enabled by defining PROG_MEM_PARITY_EN.
package prog_mem_pkg;

  localparam int unsigned LD_BYTE_W = 8;

  typedef enum logic [1:0] {StIdle, StHi, StLo, StDone} ld_state_e;

  // Even-parity bit: XOR of the stored word and this bit is zero.
  function automatic logic even_par(input logic [2*LD_BYTE_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/prog_mem_bank_if.sv
// Fetch port and byte-serial loader port of the banked program memory.
interface prog_mem_bank_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
);
  logic [BANK_W-1:0]    bank_sel;
  logic [ADDR_W-1:0]    fetch_addr;
  logic [DATA_W-1:0]    fetch_data;
  logic                 cpu_hold;
  logic                 ld_start;
  logic [BANK_W-1:0]    ld_bank;
  logic                 ld_valid;
  logic [LD_BYTE_W-1:0] ld_byte;
  logic                 ld_last;
  logic                 ld_ready;
  logic                 ld_busy;
  logic                 ld_done;
  logic                 par_err;

  modport master (
    output bank_sel, fetch_addr, ld_start, ld_bank, ld_valid, ld_byte, ld_last,
    input  fetch_data, cpu_hold, ld_ready, ld_busy, ld_done, par_err
  );

  modport slave (
    input  bank_sel, fetch_addr, ld_start, ld_bank, ld_valid, ld_byte, ld_last,
    output fetch_data, cpu_hold, ld_ready, ld_busy, ld_done, par_err
  );

endinterface

// File: rtl/prog_mem_bank_loader.sv
// Loader FSM (module prog_mem_loader): assembles byte pairs into words and drives
// the array write port with valid/ready handshaking.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_start_i,
  input  logic [BANK_W-1:0]      ld_bank_i,
  input  logic                   ld_valid_i,
  input  logic [LD_BYTE_W-1:0]   ld_byte_i,
  input  logic                   ld_last_i,
  output logic                   ld_ready_o,
  output logic                   ld_busy_o,
  output logic                   ld_done_o,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      waddr_o,
  output logic [2*LD_BYTE_W-1:0] wdata_o,
  output logic [BANK_W-1:0]      wbank_o
);

  ld_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    wp_q, wp_d;
  logic [LD_BYTE_W-1:0] hi_q, hi_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic                 fin_q, fin_d;
  logic                 bank_ok;

  assign bank_ok = {1'b0, ld_bank_i} < (BANK_W + 1)'(BANKS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wp_q    <= '0;
      hi_q    <= '0;
      bank_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      hi_q    <= hi_d;
      bank_q  <= bank_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    hi_d       = hi_q;
    bank_d     = bank_q;
    fin_d      = 1'b0;
    ld_ready_o = 1'b0;
    we_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_start_i && bank_ok) begin
          bank_d  = ld_bank_i;
          wp_d    = '0;
          state_d = StHi;
        end
      end
      StHi: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          hi_d    = ld_byte_i;
          state_d = StLo;
        end
      end
      StLo: begin
        // After the final write, spend one closed cycle in LO so DONE lands one edge later.
        if (fin_q) begin
          state_d = StDone;
        end else begin
          ld_ready_o = 1'b1;
          if (ld_valid_i) begin
            we_o = 1'b1;
            if (ld_last_i || (wp_q == '1)) begin
              fin_d = 1'b1;
            end else begin
              wp_d    = wp_q + 1'b1;
              state_d = StHi;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ld_busy_o = (state_q != StIdle);
  assign ld_done_o = (state_q == StDone);
  assign waddr_o   = wp_q;
  assign wdata_o   = {hi_q, ld_byte_i};
  assign wbank_o   = bank_q;

endmodule

// File: rtl/prog_mem_bank.sv
// Banked, loadable program memory with registered fetch and CPU hold.
// Define PROG_MEM_PARITY_EN to store and check an even-parity bit per word.
module prog_mem_bank
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input logic            clk,
  input logic            reset,
  prog_mem_bank_if.slave pm_io
);

`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif

  logic [MemW-1:0]   mem_q [0:BANKS-1][0:(1<<ADDR_W)-1];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [BANK_W-1:0] wbank;
  logic [MemW-1:0]   wword;
  logic [MemW-1:0]   rd_word;
  logic              bank_ok;
  logic              ld_busy;
  logic              cpu_hold;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;

  prog_mem_loader #(
    .ADDR_W (ADDR_W),
    .BANKS  (BANKS),
    .BANK_W (BANK_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .ld_start_i (pm_io.ld_start),
    .ld_bank_i  (pm_io.ld_bank),
    .ld_valid_i (pm_io.ld_valid),
    .ld_byte_i  (pm_io.ld_byte),
    .ld_last_i  (pm_io.ld_last),
    .ld_ready_o (pm_io.ld_ready),
    .ld_busy_o  (ld_busy),
    .ld_done_o  (pm_io.ld_done),
    .we_o       (we),
    .waddr_o    (waddr),
    .wdata_o    (wdata),
    .wbank_o    (wbank)
  );

`ifdef PROG_MEM_PARITY_EN
  assign wword = {even_par(wdata), wdata};
`else
  assign wword = wdata;
`endif

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbank][waddr] <= wword;
    end
  end

  assign bank_ok  = {1'b0, pm_io.bank_sel} < (BANK_W + 1)'(BANKS);
  assign cpu_hold = ld_busy && (pm_io.bank_sel == wbank);

  always_comb begin
    rd_word = '0;
    if (bank_ok) begin
      rd_word = mem_q[pm_io.bank_sel][pm_io.fetch_addr];
    end
    fetch_data_d = cpu_hold ? '0 : rd_word[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_data_q <= '0;
    end else begin
      fetch_data_q <= fetch_data_d;
    end
  end

`ifdef PROG_MEM_PARITY_EN
  logic par_err_q, par_err_d;

  // A stored word with its parity bit XORs to zero when intact.
  assign par_err_d = par_err_q | (!cpu_hold && bank_ok && (^rd_word));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign pm_io.par_err = par_err_q;
`else
  assign pm_io.par_err = 1'b0;
`endif

  assign pm_io.fetch_data = fetch_data_q;
  assign pm_io.cpu_hold   = cpu_hold;
  assign pm_io.ld_busy    = ld_busy;

endmodule

// File: tb/tb_prog_mem_bank.sv
// Directed bench for prog_mem_bank: reset, load/fetch, hold, wrap load, mid-load reset, parity.
module tb_prog_mem_bank;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prog_mem_bank_if #(.ADDR_W(8), .DATA_W(16), .BANKS(2), .BANK_W(1)) bus ();

  prog_mem_bank #(.ADDR_W(8), .DATA_W(16), .BANKS(2), .BANK_W(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .pm_io (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    logic rdy;
    int   n;
    bus.ld_valid = 1'b0;
    repeat (gap) tick();
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    n = 0;
    do begin
      rdy = bus.ld_ready;
      tick();
      n++;
    end while (!rdy && n < 40);
    check("byte_accepted", {31'b0, rdy}, 32'd1);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic last, input int gap);
    send_byte(w[15:8], 1'b0, gap);
    send_byte(w[7:0], last, gap);
  endtask

  task automatic start_load(input logic bank);
    bus.ld_bank  = bank;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 10; n++) begin
      if (bus.ld_done) break;
      tick();
    end
    check(tag, {31'b0, bus.ld_done}, 32'd1);
    tick();
  endtask

  task automatic fetch(input logic bank, input logic [7:0] addr, input logic [15:0] exp,
                       input string tag);
    bus.bank_sel   = bank;
    bus.fetch_addr = addr;
    tick();
    check(tag, {16'b0, bus.fetch_data}, {16'b0, exp});
  endtask

  function automatic logic [15:0] wrap_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b ^ 8'h5A, b};
  endfunction

  initial begin
    reset          = 1'b1;
    bus.bank_sel   = '0;
    bus.fetch_addr = '0;
    bus.ld_start   = 1'b0;
    bus.ld_bank    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_byte    = '0;
    bus.ld_last    = 1'b0;
    tick();
    tick();
    check("rst_fetch_data", {16'b0, bus.fetch_data}, 32'h0);
    check("rst_ld_ready", {31'b0, bus.ld_ready}, 32'd0);
    check("rst_ld_busy", {31'b0, bus.ld_busy}, 32'd0);
    check("rst_ld_done", {31'b0, bus.ld_done}, 32'd0);
    check("rst_cpu_hold", {31'b0, bus.cpu_hold}, 32'd0);
    check("rst_par_err", {31'b0, bus.par_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic load of bank 1, then exact completion timing.
    start_load(1'b1);
    check("busy_after_start", {31'b0, bus.ld_busy}, 32'd1);
    send_word(16'h2280, 1'b0, 0);
    send_word(16'h2C00, 1'b1, 0);
    check("done_edge0", {31'b0, bus.ld_done}, 32'd0);
    check("ready_after_last", {31'b0, bus.ld_ready}, 32'd0);
    tick();
    check("done_edge1", {31'b0, bus.ld_done}, 32'd1);
    tick();
    check("done_edge2", {31'b0, bus.ld_done}, 32'd0);
    check("busy_edge2", {31'b0, bus.ld_busy}, 32'd0);
    fetch(1'b1, 8'd0, 16'h2280, "basic_w0");
    fetch(1'b1, 8'd1, 16'h2C00, "basic_w1");

    // Load bank 0 while fetching bank 1, then switch onto the loading bank.
    start_load(1'b0);
    check("hold_other_bank", {31'b0, bus.cpu_hold}, 32'd0);
    send_byte(8'hAB, 1'b0, 0);
    check("concurrent_fetch", {16'b0, bus.fetch_data}, 32'h2C00);
    bus.fetch_addr = 8'd0;
    tick();
    check("concurrent_fetch0", {16'b0, bus.fetch_data}, 32'h2280);
    bus.bank_sel = 1'b0;
    #1;
    check("hold_same_bank", {31'b0, bus.cpu_hold}, 32'd1);
    tick();
    check("held_fetch_zero", {16'b0, bus.fetch_data}, 32'h0);
    send_byte(8'hCD, 1'b0, 1);
    send_word(16'h1234, 1'b1, 0);
    wait_done("hold_load_done");
    check("hold_released", {31'b0, bus.cpu_hold}, 32'd0);
    fetch(1'b0, 8'd0, 16'hABCD, "hold_w0");
    fetch(1'b0, 8'd1, 16'h1234, "hold_w1");

    // Full-bank load with gaps and no ld_last; must end on the last address.
    bus.bank_sel = 1'b1;
    start_load(1'b0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("busy_before_w255", {31'b0, bus.ld_busy}, 32'd1);
      send_word(wrap_word(i), 1'b0, $urandom_range(0, 2));
    end
    wait_done("wrap_done");
    for (int i = 0; i < 256; i++) begin
      fetch(1'b0, i[7:0], wrap_word(i), "wrap_readback");
    end
    fetch(1'b1, 8'd0, 16'h2280, "bank1_intact");

    // Asynchronous reset in the middle of a load.
    start_load(1'b1);
    send_word(16'hA1B1, 1'b0, 0);
    send_word(16'hA2B2, 1'b0, 0);
    send_word(16'hA3B3, 1'b0, 0);
    send_byte(8'hA4, 1'b0, 0);
    check("hold_midload", {31'b0, bus.cpu_hold}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, bus.ld_busy}, 32'd0);
    check("mid_rst_hold", {31'b0, bus.cpu_hold}, 32'd0);
    check("mid_rst_ready", {31'b0, bus.ld_ready}, 32'd0);
    check("mid_rst_done", {31'b0, bus.ld_done}, 32'd0);
    check("mid_rst_fetch", {16'b0, bus.fetch_data}, 32'h0);
    #1 reset = 1'b0;
    tick();
    check("post_rst_busy", {31'b0, bus.ld_busy}, 32'd0);
    fetch(1'b1, 8'd0, 16'hA1B1, "partial_w0");
    fetch(1'b1, 8'd1, 16'hA2B2, "partial_w1");
    fetch(1'b1, 8'd2, 16'hA3B3, "partial_w2");

`ifdef PROG_MEM_PARITY_EN
    fetch(1'b0, 8'd5, wrap_word(5), "par_clean_word");
    check("par_clean", {31'b0, bus.par_err}, 32'd0);
    u_dut.mem_q[0][5][0] = ~u_dut.mem_q[0][5][0];
    fetch(1'b0, 8'd5, wrap_word(5) ^ 16'h0001, "par_flipped_word");
    check("par_set", {31'b0, bus.par_err}, 32'd1);
    bus.fetch_addr = 8'd6;
    tick();
    tick();
    check("par_sticky", {31'b0, bus.par_err}, 32'd1);
    reset = 1'b1;
    #1;
    check("par_rst", {31'b0, bus.par_err}, 32'd0);
    reset = 1'b0;
`else
    fetch(1'b0, 8'd5, wrap_word(5), "nopar_word");
    check("par_tied_low", {31'b0, bus.par_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem_bank.md
# prog_mem_bank

Banked, loadable program memory for the 8-bit CPU. It replaces fixed per-program ROM images with `BANKS` writable program banks. A byte-serial loader fills them with valid/ready handshaking, and the CPU fetches with one-cycle registered latency. It sits between the CPU fetch port (PC in, 16-bit instruction out) and the board-level load source (UART/switch front end).

## Interface
- `ADDR_W`, 8: fetch address width; each bank holds 2^ADDR_W words.
- `DATA_W`, 16: instruction width; fixed at 16 because loader framing is two bytes.
- `BANKS`, 2: number of program banks, ≥1. `BANK_W` = max(1, $clog2(BANKS)).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `bank_sel` in BANK_W: bank used for fetch.
- `fetch_addr` in ADDR_W: CPU program counter.
- `fetch_data` out DATA_W: registered instruction.
- `cpu_hold` out 1: the selected bank is being loaded; CPU must stall.
- `ld_start` in 1: single-cycle pulse; begins a load of `ld_bank` at word 0.
- `ld_bank` in BANK_W: target bank, sampled on `ld_start`.
- `ld_valid` in 1: `ld_byte` is valid.
- `ld_byte` in 8: load byte; high byte first, then low byte.
- `ld_last` in 1: qualifies a low byte as the final word of the load.
- `ld_ready` out 1: loader accepts a byte this cycle.
- `ld_busy` out 1: load in progress.
- `ld_done` out 1: one-cycle pulse at load completion.
- `par_err` out 1: sticky parity error (see Configuration).

## Operation
- Storage: BANKS × 2^ADDR_W × DATA_W array, not reset. Contents are undefined until loaded.
- Fetch: `fetch_data` ← mem[`bank_sel`][`fetch_addr`] every cycle.
  - While `cpu_hold`=1, `fetch_data` ← 16'h0000 instead.
- `cpu_hold` = `ld_busy` AND (`bank_sel` == latched load bank). This is combinational from state and `bank_sel`.
- Loader FSM:
  - IDLE: `ld_ready`=0. On `ld_start`: latch `ld_bank`, set word pointer `wp`=0, go to HI.
  - HI: `ld_ready`=1. On `ld_valid`: latch the byte into `hi_reg`, go to LO.
  - LO: `ld_ready`=1. On `ld_valid`: write {`hi_reg`, `ld_byte`} to mem[bank][`wp`].
    - If `ld_last`=1 or `wp`=2^ADDR_W−1: go to DONE.
    - Otherwise: `wp`++, go to HI.
  - DONE: `ld_done`=1 for one cycle, `ld_ready`=0, go to IDLE.
- A byte transfer completes only when `ld_valid` and `ld_ready` are both 1 at a rising edge.
- `ld_last` is ignored in HI.
- `ld_start` is ignored outside IDLE.
- `ld_bank` ≥ BANKS: `ld_start` is ignored, and the FSM stays in IDLE.
- `ld_busy` = 1 in HI, LO and DONE.
- Loading one bank while fetching another is fully concurrent, with no stall.
- Mid-load `reset`: the FSM returns to IDLE immediately. Words already written remain in the array; the partial bank is not valid.

## Timing
- Reset values:
  - `fetch_data`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `cpu_hold`=0, `par_err`=0.
  - FSM=IDLE, `wp`=0, `hi_reg`=0.
- Fetch latency: 1 cycle, from `fetch_addr`/`bank_sel` to `fetch_data`.
- Write: a word is written at the edge that accepts its low byte. A fetch of that address in the following cycle returns the new word, once hold is released.
- Minimum load rate: 2 cycles per word.
- Timing from the last accepted byte:
  - edge 0: write.
  - edge 1: enter DONE.
  - edge 2: enter IDLE. `ld_done` is high between edges 1 and 2, and `cpu_hold` deasserts.
- First valid fetch after a load: `fetch_data` is valid one cycle after `cpu_hold` falls.

## Configuration
- `PROG_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed at write.
  - On each fetch not under hold, the bank read is checked; a mismatch sets `par_err` one cycle after the read, alongside `fetch_data`.
  - `par_err` stays set until `reset`.
- Not defined: no parity storage, and `par_err` is tied to 0. The port is always present.

## Structure
- Shared package `prog_mem_pkg`:
  - loader state enum {IDLE, HI, LO, DONE}.
  - `LD_BYTE_W`=8.
  - parity function `even_par`.
- One sub-module, `prog_mem_loader`: the FSM, `wp`, `hi_reg`, and the handshake outputs. It drives the write enable, address, data and bank to the top-level array.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, FSM in IDLE.
- Basic load/fetch:
  - `ld_start`, `ld_bank`=1; send bytes 0x22, 0x80, 0x2C, 0x00 with `ld_last` on the 4th byte.
  - Required: `ld_done` pulses 2 cycles after the 4th byte.
  - Then `bank_sel`=1 with `fetch_addr` 0 and 1 → 0x2280 and 0x2C00, each one cycle later.
- Hold/concurrency:
  - Load bank 0 while `bank_sel`=1 → `cpu_hold`=0 and bank 1 fetches unaffected.
  - Switch `bank_sel`=0 mid-load → `cpu_hold`=1 and `fetch_data`=0.
- Backpressure/wrap:
  - Random `ld_valid` gaps, ADDR_W=8, no `ld_last`.
  - Required: after 256 words, `ld_done` pulses at `wp`=255 and all 256 words read back correctly.
- Mid-load reset: `reset` after 3 words → `ld_busy`=0, `cpu_hold`=0, words 0–2 retain their written values.
- Parity (macro on): backdoor-flip one data bit of bank 0 word 5, fetch it → `par_err`=1 one cycle later, and it stays 1 until reset.
